fruit_engine: RTL and testbench
===============================

Name: fruit_engine

Overview:
- Parametrised successor to the single-fruit motion block.
- Manages N_FRUITS independent fruit slots. Each slot has its own position, velocity, gravity and LFSR-driven spawning.
- Detects blade slices against a cursor and keeps score and miss counters.
- Sits between the VGA timing generator (VS drives frame ticks) and the colour mapper (consumes per-slot X/Y/state).

Parameters:
- N_FRUITS, 4, number of fruit slots (1..8)
- COORD_W, 10, screen coordinate width
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- FRUIT_SIZE, 16, half-extent of the slice hit box in pixels
- GRAVITY, 1, vy increment per frame
- VY_MAX, 31, positive vy saturation
- SPAWN_PERIOD, 60, frames between spawn attempts
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero)
- SCORE_W, 8, width of the score and missed counters

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- frame_vs  in  1  VGA VS, active low; its falling edge is the frame tick
- enable  in  1  game running; when low, ticks are ignored
- game_clear  in  1  synchronous pulse; frees all slots and zeroes the counters
- blade_x  in  COORD_W  blade cursor X
- blade_y  in  COORD_W  blade cursor Y
- blade_active  in  1  blade is cutting
- fruit_x  out  N_FRUITS*COORD_W  packed slot X positions, slot 0 in the LSBs
- fruit_y  out  N_FRUITS*COORD_W  packed slot Y positions
- fruit_live  out  N_FRUITS  slot state is not FREE
- fruit_sliced  out  N_FRUITS  slot state is SLICED
- score  out  SCORE_W  slices, saturating
- missed  out  SCORE_W  unsliced fruits lost off the bottom, saturating
- busy  out  1  per-frame update in progress

Behaviour:
- Reset:
  - All slots FREE, with x=y=vx=vy=0.
  - All outputs 0.
  - LFSR = LFSR_SEED, frame counter = 0, FSM in IDLE.
- Tick detect: frame_vs is registered once; a tick is prev=1 and cur=0. A tick is accepted only in IDLE with enable=1. Otherwise it is dropped.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE goes to UPDATE on an accepted tick (cycle T), with idx=0.
  - UPDATE processes slot idx at cycle T+1+idx. After idx=N_FRUITS-1 it goes to SPAWN at T+1+N_FRUITS.
  - SPAWN always returns to IDLE.
  - busy = 1 in UPDATE and SPAWN.
- Slot state per slot: FREE, FLYING, SLICED.
- Physics (UPDATE, non-FREE slot):
  - Internal x and y are signed COORD_W+1; vx is signed 4-bit; vy is signed 8-bit.
  - Apply y'=y+vy, x'=x+vx, then vy'=min(vy+GRAVITY, VY_MAX).
  - If x'<0: clamp x to 0 and negate vx. If x'>SCREEN_W-1: clamp to SCREEN_W-1 and negate vx.
  - If y'<0: clamp y to 0 and set vy'=0.
  - If y'>=SCREEN_H: slot becomes FREE. If the state was FLYING, missed increments.
  - Otherwise, if the state is FLYING, blade_active=1, |blade_x-x'|<FRUIT_SIZE and |blade_y-y'|<FRUIT_SIZE: state becomes SLICED and score increments.
  - SLICED slots keep falling and never count as missed.
- Frame counter: increments in SPAWN.
- Spawn attempt: occurs in SPAWN when the counter equals SPAWN_PERIOD-1; the counter then resets to 0.
  - The lowest-index FREE slot is loaded from the current LFSR value L:
    - x = 64 + L[8:0]
    - y = SCREEN_H-1
    - vy = -(12 + L[11:9])
    - vx = +L[13:12] if x<SCREEN_W/2, else -L[13:12]
    - state = FLYING
  - A newly spawned fruit receives no physics in its spawn frame.
  - The LFSR advances one step after every attempt, including skipped ones.
  - No free slot: the spawn is skipped and the counter still resets.
- LFSR: 16-bit Fibonacci, feedback bit = L[15]^L[13]^L[12]^L[10], shifted into the LSB.
- Outputs are registered and change only at a slot's UPDATE or SPAWN cycle.
- Counters saturate at 2^SCORE_W-1.
- game_clear:
  - Takes priority over everything else.
  - Frees all slots, zeroes score, missed and the frame counter, and forces IDLE.
  - The LFSR is kept.
- enable falling mid-frame: the current UPDATE/SPAWN pass completes; later ticks are ignored.
- Reset_n asserted mid-pass: everything returns to reset values immediately.

Decomposition:
- fruit_pkg holds:
  - slot_state_t enum {FREE, FLYING, SLICED}
  - fsm_t enum {IDLE, UPDATE, SPAWN}
  - fruit_slot_t struct {x, y, vx, vy, state}
  - the constants SPAWN_X_BASE=64 and SPAWN_VY_BASE=12
- Sub-module lfsr16 has ports Clk, Reset_n, step, seed, value.

Test Plan:
- Reset: hold Reset_n=0 -> all outputs 0, busy=0. Release and apply no ticks -> outputs stay 0.
- Spawn with SPAWN_PERIOD=4 and seed ACE1: 4 ticks -> slot0 live with x=289, y=479 (vx=+2, vy=-18). Tick 5 -> x=291, y=461.
- Slice: on tick 5, blade (295,465) with blade_active=1 -> fruit_sliced[0]=1, score=1. Further ticks at the same spot -> score stays 1, and the slot frees later with missed=0.
- Miss: no blade -> on the 38th update after spawn, y'=498 -> fruit_live[0]=0, missed=1.
- Full slots with N_FRUITS=2, SPAWN_PERIOD=1: ticks 1 and 2 fill slots 0 and 1; tick 3 skips the spawn. The LFSR still advances: after the attempt it differs from its value before the attempt.
- Edges:
  - A tick while busy is dropped.
  - game_clear mid-UPDATE -> all free and score=0.
  - Reset_n pulsed mid-pass -> immediate reset values.
  - Score saturates at 255 with SCORE_W=8.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared types and constants for the multi-slot fruit engine.
package fruit_pkg;

    typedef enum logic [1:0] {FREE, FLYING, SLICED} slot_state_t;
    typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} fsm_t;

    // Positions are held wider than any supported COORD_W, so one struct serves every instance.
    localparam int POS_W         = 16;
    localparam int SPAWN_X_BASE  = 64;
    localparam int SPAWN_VY_BASE = 12;

    typedef struct packed {
        logic signed [POS_W-1:0] x;
        logic signed [POS_W-1:0] y;
        logic signed [3:0]       vx;
        logic signed [7:0]       vy;
        slot_state_t             state;
    } fruit_slot_t;

endpackage

// File: rtl/fruit_engine_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10) that advances one step per strobe.
module lfsr16 (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            value <= seed;
        else if (step)
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end

endmodule

// File: rtl/fruit_engine.sv
// N-slot fruit motion engine: per-frame sequential slot physics, blade slicing,
// LFSR-driven spawning, score and miss counters.
module fruit_engine
    import fruit_pkg::*;
#(
    parameter int          N_FRUITS     = 4,
    parameter int          COORD_W      = 10,
    parameter int          SCREEN_W     = 640,
    parameter int          SCREEN_H     = 480,
    parameter int          FRUIT_SIZE   = 16,
    parameter int          GRAVITY      = 1,
    parameter int          VY_MAX       = 31,
    parameter int          SPAWN_PERIOD = 60,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          SCORE_W      = 8
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_vs,
    input  logic                         enable,
    input  logic                         game_clear,
    input  logic [COORD_W-1:0]           blade_x,
    input  logic [COORD_W-1:0]           blade_y,
    input  logic                         blade_active,
    output logic [N_FRUITS*COORD_W-1:0]  fruit_x,
    output logic [N_FRUITS*COORD_W-1:0]  fruit_y,
    output logic [N_FRUITS-1:0]          fruit_live,
    output logic [N_FRUITS-1:0]          fruit_sliced,
    output logic [SCORE_W-1:0]           score,
    output logic [SCORE_W-1:0]           missed,
    output logic                         busy
);

    localparam int IDX_W = (N_FRUITS > 1) ? $clog2(N_FRUITS) : 1;
    localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(N_FRUITS - 1);
    localparam logic signed [POS_W-1:0] XMAX    = POS_W'(SCREEN_W - 1);
    localparam logic signed [POS_W-1:0] XHALF   = POS_W'(SCREEN_W / 2);
    localparam logic signed [POS_W-1:0] YLIM    = POS_W'(SCREEN_H);
    localparam logic signed [POS_W-1:0] YTOP    = POS_W'(SCREEN_H - 1);
    localparam logic signed [POS_W-1:0] HIT_R   = POS_W'(FRUIT_SIZE);
    localparam logic signed [7:0]       VY_CAP  = 8'(VY_MAX);
    localparam logic signed [7:0]       VY_TRIP = 8'(VY_MAX - GRAVITY);
    localparam logic signed [7:0]       GRAV    = 8'(GRAVITY);

    fruit_slot_t        slots [N_FRUITS];
    fsm_t               fsm;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   fcnt;
    logic               vs_q;
    logic [15:0]        lfsr;
    logic               tick, attempt;

    assign tick    = vs_q & ~frame_vs;
    assign attempt = (fsm == SPAWN) && (fcnt == CNT_LAST) && !game_clear;
    assign busy    = (fsm != IDLE);

    lfsr16 u_lfsr (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .step    (attempt),
        .seed    (LFSR_SEED),
        .value   (lfsr)
    );

    // Physics for the slot selected by idx
    fruit_slot_t             cur, nxt;
    logic signed [POS_W-1:0] nx, ny, dx, dy, ax, ay;
    logic signed [7:0]       nvy;
    logic                    inc_score, inc_miss;

    assign cur = slots[idx];

    always_comb begin
        nx  = cur.x + {{(POS_W-4){cur.vx[3]}}, cur.vx};
        ny  = cur.y + {{(POS_W-8){cur.vy[7]}}, cur.vy};
        nvy = (cur.vy >= VY_TRIP) ? VY_CAP : cur.vy + GRAV;
        dx  = signed'({{(POS_W-COORD_W){1'b0}}, blade_x}) - nx;
        dy  = signed'({{(POS_W-COORD_W){1'b0}}, blade_y}) - ny;
        ax  = dx[POS_W-1] ? -dx : dx;
        ay  = dy[POS_W-1] ? -dy : dy;
        nxt       = cur;
        inc_score = 1'b0;
        inc_miss  = 1'b0;
        if (nx < 0) begin
            nxt.x  = '0;
            nxt.vx = -cur.vx;
        end else if (nx > XMAX) begin
            nxt.x  = XMAX;
            nxt.vx = -cur.vx;
        end else begin
            nxt.x = nx;
        end
        if (ny < 0) begin
            nxt.y  = '0;
            nxt.vy = '0;
        end else begin
            nxt.y  = ny;
            nxt.vy = nvy;
        end
        if (ny >= YLIM) begin
            nxt.state = FREE;
            inc_miss  = (cur.state == FLYING);
        end else if (cur.state == FLYING && blade_active && ax < HIT_R && ay < HIT_R) begin
            nxt.state = SLICED;
            inc_score = 1'b1;
        end
    end

    // Spawn candidate: lowest-index free slot, loaded from the current LFSR value
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    fruit_slot_t      sp;
    logic signed [3:0] sp_v;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = N_FRUITS - 1; i >= 0; i--) begin
            if (slots[i].state == FREE) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        sp_v     = {2'b00, lfsr[13:12]};
        sp.x     = POS_W'(SPAWN_X_BASE) + POS_W'(lfsr[8:0]);
        sp.y     = YTOP;
        sp.vy    = -(8'(SPAWN_VY_BASE) + {5'b0, lfsr[11:9]});
        sp.vx    = (sp.x < XHALF) ? sp_v : -sp_v;
        sp.state = FLYING;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm    <= IDLE;
            idx    <= '0;
            fcnt   <= '0;
            vs_q   <= 1'b0;
            score  <= '0;
            missed <= '0;
            for (int i = 0; i < N_FRUITS; i++) slots[i] <= '0;
        end else begin
            vs_q <= frame_vs;
            if (game_clear) begin
                fsm    <= IDLE;
                idx    <= '0;
                fcnt   <= '0;
                score  <= '0;
                missed <= '0;
                for (int i = 0; i < N_FRUITS; i++) slots[i] <= '0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (tick && enable) begin
                            fsm <= UPDATE;
                            idx <= '0;
                        end
                    end
                    UPDATE: begin
                        if (cur.state != FREE) begin
                            slots[idx] <= nxt;
                            if (inc_score && score != '1) score <= score + 1'b1;
                            if (inc_miss && missed != '1) missed <= missed + 1'b1;
                        end
                        if (idx == IDX_LAST) fsm <= SPAWN;
                        else                 idx <= idx + 1'b1;
                    end
                    SPAWN: begin
                        fsm <= IDLE;
                        if (fcnt == CNT_LAST) begin
                            fcnt <= '0;
                            if (free_found) slots[free_idx] <= sp;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end

    logic [N_FRUITS-1:0] unused_hi;
    logic                unused_lfsr;
    assign unused_lfsr = ^lfsr[15:14];

    for (genvar i = 0; i < N_FRUITS; i++) begin : g_out
        assign fruit_x[i*COORD_W +: COORD_W] = slots[i].x[COORD_W-1:0];
        assign fruit_y[i*COORD_W +: COORD_W] = slots[i].y[COORD_W-1:0];
        assign fruit_live[i]   = (slots[i].state != FREE);
        assign fruit_sliced[i] = (slots[i].state == SLICED);
        assign unused_hi[i]    = ^{slots[i].x[POS_W-1:COORD_W], slots[i].y[POS_W-1:COORD_W]};
    end

endmodule

// File: tb/tb_fruit_engine.sv
// Bench for fruit_engine: directed table, hand sequences, and randomized frames
// checked against an integer reference model of the game rules.
module tb_fruit_engine;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic Reset_n;

    // dut_a: 4 slots, spawn every 4 frames, full screen
    logic        fvs_a, en_a, gc_a, ba_a;
    logic [9:0]  bx_a, by_a;
    logic [39:0] fx_a, fy_a;
    logic [3:0]  live_a, sl_a;
    logic [7:0]  score_a, missed_a;
    logic        busy_a;
    // dut_b: 2 slots, spawn every frame, short screen, blade hits everywhere
    logic        fvs_b, en_b, gc_b, ba_b;
    logic [9:0]  bx_b, by_b;
    logic [19:0] fx_b, fy_b;
    logic [1:0]  live_b, sl_b;
    logic [7:0]  score_b, missed_b;
    logic        busy_b;

    fruit_engine #(.N_FRUITS(4), .SPAWN_PERIOD(4)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(fvs_a), .enable(en_a), .game_clear(gc_a),
        .blade_x(bx_a), .blade_y(by_a), .blade_active(ba_a), .fruit_x(fx_a), .fruit_y(fy_a),
        .fruit_live(live_a), .fruit_sliced(sl_a), .score(score_a), .missed(missed_a), .busy(busy_a));

    fruit_engine #(.N_FRUITS(2), .SPAWN_PERIOD(1), .SCREEN_H(40), .FRUIT_SIZE(1023)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(fvs_b), .enable(en_b), .game_clear(gc_b),
        .blade_x(bx_b), .blade_y(by_b), .blade_active(ba_b), .fruit_x(fx_b), .fruit_y(fy_b),
        .fruit_live(live_b), .fruit_sliced(sl_b), .score(score_b), .missed(missed_b), .busy(busy_b));

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int c_n[2]  = '{4, 2};
    int c_p[2]  = '{4, 1};
    int c_h[2]  = '{480, 40};
    int c_fs[2] = '{16, 1023};
    int m_x[2][8], m_y[2][8], m_vx[2][8], m_vy[2][8], m_st[2][8]; // st: 0 free, 1 flying, 2 sliced
    int m_score[2], m_missed[2], m_cnt[2];
    logic [15:0] m_lfsr[2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic model_clear(input int d);
        for (int s = 0; s < 8; s++) begin
            m_x[d][s] = 0; m_y[d][s] = 0; m_vx[d][s] = 0; m_vy[d][s] = 0; m_st[d][s] = 0;
        end
        m_score[d] = 0; m_missed[d] = 0; m_cnt[d] = 0;
    endtask

    task automatic model_reset(input int d);
        model_clear(d);
        m_lfsr[d] = 16'hACE1;
    endtask

    task automatic model_frame(input int d, input bit ba, input int bx, input int by);
        int nx, ny, f, L, v;
        for (int s = 0; s < c_n[d]; s++) begin
            if (m_st[d][s] == 0) continue;
            nx = m_x[d][s] + m_vx[d][s];
            ny = m_y[d][s] + m_vy[d][s];
            if (nx < 0)        begin m_x[d][s] = 0;   m_vx[d][s] = -m_vx[d][s]; end
            else if (nx > 639) begin m_x[d][s] = 639; m_vx[d][s] = -m_vx[d][s]; end
            else m_x[d][s] = nx;
            if (ny < 0) begin m_y[d][s] = 0; m_vy[d][s] = 0; end
            else begin
                m_y[d][s] = ny;
                m_vy[d][s] = (m_vy[d][s] + 1 > 31) ? 31 : m_vy[d][s] + 1;
            end
            if (ny >= c_h[d]) begin
                if (m_st[d][s] == 1 && m_missed[d] < 255) m_missed[d]++;
                m_st[d][s] = 0;
            end else if (m_st[d][s] == 1 && ba && (bx - nx < c_fs[d]) && (nx - bx < c_fs[d])
                         && (by - ny < c_fs[d]) && (ny - by < c_fs[d])) begin
                m_st[d][s] = 2;
                if (m_score[d] < 255) m_score[d]++;
            end
        end
        if (m_cnt[d] == c_p[d] - 1) begin
            m_cnt[d] = 0;
            f = -1;
            for (int s = c_n[d] - 1; s >= 0; s--) if (m_st[d][s] == 0) f = s;
            if (f >= 0) begin
                L = int'(m_lfsr[d]);
                v = (L >> 12) & 3;
                m_x[d][f]  = 64 + (L & 511);
                m_y[d][f]  = c_h[d] - 1;
                m_vy[d][f] = -(12 + ((L >> 9) & 7));
                m_vx[d][f] = (m_x[d][f] < 320) ? v : -v;
                m_st[d][f] = 1;
            end
            m_lfsr[d] = lfsr_next(m_lfsr[d]);
        end else begin
            m_cnt[d]++;
        end
    endtask

    // ---------------- DUT access ----------------
    function automatic int get_x(input int d, input int s);
        if (d == 0) return int'((fx_a >> (10 * s)) & 40'h3FF);
        return int'((fx_b >> (10 * s)) & 20'h3FF);
    endfunction
    function automatic int get_y(input int d, input int s);
        if (d == 0) return int'((fy_a >> (10 * s)) & 40'h3FF);
        return int'((fy_b >> (10 * s)) & 20'h3FF);
    endfunction
    function automatic int get_live(input int d, input int s);
        return (d == 0) ? int'(live_a[s]) : int'(live_b[s[0]]);
    endfunction
    function automatic int get_sl(input int d, input int s);
        return (d == 0) ? int'(sl_a[s]) : int'(sl_b[s[0]]);
    endfunction

    task automatic check_dut(input int d);
        for (int s = 0; s < c_n[d]; s++) begin
            chk($sformatf("d%0d_live%0d", d, s), get_live(d, s), int'(m_st[d][s] != 0));
            chk($sformatf("d%0d_sliced%0d", d, s), get_sl(d, s), int'(m_st[d][s] == 2));
            if (m_st[d][s] != 0) begin
                chk($sformatf("d%0d_x%0d", d, s), get_x(d, s), m_x[d][s]);
                chk($sformatf("d%0d_y%0d", d, s), get_y(d, s), m_y[d][s]);
            end
        end
        chk($sformatf("d%0d_score", d), (d == 0) ? int'(score_a) : int'(score_b), m_score[d]);
        chk($sformatf("d%0d_missed", d), (d == 0) ? int'(missed_a) : int'(missed_b), m_missed[d]);
        chk($sformatf("d%0d_busy", d), (d == 0) ? int'(busy_a) : int'(busy_b), 0);
    endtask

    bit cur_ba[2];
    int cur_bx[2], cur_by[2];

    task automatic set_blade(input int d, input bit ba, input int bx, input int by);
        cur_ba[d] = ba; cur_bx[d] = bx; cur_by[d] = by;
        if (d == 0) begin ba_a = ba; bx_a = 10'(bx); by_a = 10'(by); end
        else        begin ba_b = ba; bx_b = 10'(bx); by_b = 10'(by); end
    endtask

    task automatic wait_idle(input int d);
        bit done = 0;
        for (int k = 0; k < 40; k++) begin
            if (((d == 0) ? busy_a : busy_b) == 1'b0) begin done = 1; break; end
            @(negedge Clk);
        end
        if (!done) chk($sformatf("d%0d_pass_timeout", d), 1, 0);
    endtask

    // One VS falling edge; called and returns at a negedge with the DUT idle.
    task automatic do_frame(input int d, input bit en);
        if (d == 0) begin en_a = en; fvs_a = 1'b0; end else begin en_b = en; fvs_b = 1'b0; end
        @(negedge Clk);
        if (d == 0) fvs_a = 1'b1; else fvs_b = 1'b1;
        if (en) begin
            wait_idle(d);
            model_frame(d, cur_ba[d], cur_bx[d], cur_by[d]);
        end else begin
            chk($sformatf("d%0d_disabled_busy", d), (d == 0) ? int'(busy_a) : int'(busy_b), 0);
            @(negedge Clk);
        end
        check_dut(d);
        if (d == 0) en_a = 1'b1; else en_b = 1'b1;
    endtask

    typedef struct {
        bit ba; int bx; int by;
        int live0; int x0; int y0; int sl0; int score;
    } vec_t;

    initial begin
        vec_t tbl[6];
        logic [15:0] l2, l3;
        int s0, fr;

        tbl[0] = '{0, 0, 0,     0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0,     0, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0,     0, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 0,     1, 289, 479, 0, 0};
        tbl[4] = '{1, 295, 465, 1, 291, 461, 1, 1};
        tbl[5] = '{1, 295, 465, 1, 293, 444, 1, 1};

        fvs_a = 1; en_a = 1; gc_a = 0; fvs_b = 1; en_b = 1; gc_b = 0;
        set_blade(0, 0, 0, 0); set_blade(1, 0, 0, 0);
        Reset_n = 0;
        model_reset(0); model_reset(1);
        repeat (3) @(negedge Clk);

        // Reset state, held and after release with no ticks
        for (int p = 0; p < 2; p++) begin
            chk("rst_fx", int'(fx_a != 0), 0);
            chk("rst_fy", int'(fy_a != 0), 0);
            chk("rst_live", int'(live_a), 0);
            chk("rst_sliced", int'(sl_a), 0);
            chk("rst_score", int'(score_a), 0);
            chk("rst_missed", int'(missed_a), 0);
            chk("rst_busy", int'(busy_a), 0);
            if (p == 0) begin
                Reset_n = 1;
                repeat (5) @(negedge Clk);
            end
        end

        // Spawn and slice from the seed value
        for (int i = 0; i < 6; i++) begin
            set_blade(0, tbl[i].ba, tbl[i].bx, tbl[i].by);
            do_frame(0, 1'b1);
            chk($sformatf("tbl%0d_live0", i), int'(live_a[0]), tbl[i].live0);
            chk($sformatf("tbl%0d_sl0", i), int'(sl_a[0]), tbl[i].sl0);
            chk($sformatf("tbl%0d_score", i), int'(score_a), tbl[i].score);
            if (tbl[i].live0 != 0) begin
                chk($sformatf("tbl%0d_x0", i), get_x(0, 0), tbl[i].x0);
                chk($sformatf("tbl%0d_y0", i), get_y(0, 0), tbl[i].y0);
            end
        end

        // Second VS edge while busy must be dropped: exactly one pass
        fvs_a = 0; @(negedge Clk); fvs_a = 1; @(negedge Clk); fvs_a = 0; @(negedge Clk); fvs_a = 1;
        wait_idle(0);
        model_frame(0, cur_ba[0], cur_bx[0], cur_by[0]);
        repeat (8) @(negedge Clk);
        check_dut(0);

        // game_clear in the middle of UPDATE
        fvs_a = 0; @(negedge Clk); fvs_a = 1; gc_a = 1; @(negedge Clk); gc_a = 0;
        @(negedge Clk);
        model_clear(0);
        chk("clr_busy", int'(busy_a), 0);
        chk("clr_live", int'(live_a), 0);
        chk("clr_score", int'(score_a), 0);
        chk("clr_missed", int'(missed_a), 0);

        // Randomized frames against the model; the blade often aims at a predicted fruit
        for (int f = 0; f < 160; f++) begin
            bit ba = ($urandom_range(0, 1) == 1);
            int bx = $urandom_range(0, 1023), by = $urandom_range(0, 1023);
            s0 = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                int s = (s0 + k) % 4;
                if (m_st[0][s] != 0 && $urandom_range(0, 2) != 0) begin
                    bx = m_x[0][s] + m_vx[0][s] + $urandom_range(0, 40) - 20;
                    by = m_y[0][s] + m_vy[0][s] + $urandom_range(0, 40) - 20;
                    if (bx < 0) bx = 0;
                    if (by < 0) by = 0;
                    break;
                end
            end
            set_blade(0, ba, bx, by);
            do_frame(0, ($urandom_range(0, 7) != 0));
        end

        // Reset_n pulsed mid-pass
        fvs_a = 0; @(negedge Clk); fvs_a = 1;
        #2 Reset_n = 0;
        #1;
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_live", int'(live_a), 0);
        chk("midrst_score", int'(score_a), 0);
        chk("midrst_missed", int'(missed_a), 0);
        chk("midrst_fx", int'(fx_a != 0), 0);
        @(negedge Clk);
        Reset_n = 1;
        model_reset(0); model_reset(1);
        @(negedge Clk);

        // Miss: unsliced seed fruit leaves the bottom on its 38th update
        set_blade(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_frame(0, 1'b1);
        for (int j = 1; j <= 38; j++) begin
            do_frame(0, 1'b1);
            if (j == 37) begin
                chk("miss_live_37", int'(live_a[0]), 1);
                chk("miss_y_37", get_y(0, 0), 479);
            end
            if (j == 38) chk("miss_live_38", int'(live_a[0]), 0);
        end
        chk("miss_counted", int'(missed_a >= 1), 1);

        // Full slots: third attempt is skipped but the LFSR still steps
        set_blade(1, 0, 0, 0);
        do_frame(1, 1'b1);
        chk("full_lfsr1", int'(dut_b.u_lfsr.value), int'(lfsr_next(16'hACE1)));
        do_frame(1, 1'b1);
        l2 = lfsr_next(lfsr_next(16'hACE1));
        l3 = lfsr_next(l2);
        chk("full_live_t2", int'(live_b), 3);
        chk("full_lfsr2", int'(dut_b.u_lfsr.value), int'(l2));
        do_frame(1, 1'b1);
        chk("full_live_t3", int'(live_b), 3);
        chk("full_lfsr3", int'(dut_b.u_lfsr.value), int'(l3));
        chk("full_lfsr_moved", int'(dut_b.u_lfsr.value != l2), 1);

        // Score saturation: blade covers the whole screen on dut_b
        set_blade(1, 1, 320, 20);
        fr = 0;
        while (m_score[1] < 255 && fr < 4000) begin
            do_frame(1, 1'b1);
            fr++;
        end
        for (int i = 0; i < 20; i++) do_frame(1, 1'b1);
        chk("sat_score", int'(score_b), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
